// File: rtl/weight_bank_ring_if.sv
// Loader and consumer channels of the weight bank ring.
// Valid/ready: a write transfers on a clock edge where wr_valid && wr_ready; wr_last only counts on a transferred write. A read or release takes effect only while the read bank is READY.
interface weight_bank_ring_if #(
   parameter int LANES      = 8,
   parameter int WORD_WIDTH = 8,
   parameter int ADDR_W     = 10
);
   logic                        wr_valid;
   logic [ADDR_W-1:0]           wr_addr;
   logic [LANES*WORD_WIDTH-1:0] wr_data;
   logic                        wr_last;
   logic                        wr_ready;
   logic                        rd_en;
   logic [ADDR_W-1:0]           rd_addr;
   logic                        rd_release;
   logic [LANES*WORD_WIDTH-1:0] rd_data;
   logic                        rd_valid;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_release,
      input  wr_ready, rd_data, rd_valid
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_release,
      output wr_ready, rd_data, rd_valid
   );
endinterface

// File: rtl/weight_bank_ring.sv
// N-bank ring of weight buffers: one bank fills while another is read; ownership
// moves by commit (wr_last) and release (rd_release) rather than by an address split.
module weight_bank_ring #(
   parameter int NUM_BANKS  = 2,
   parameter int LANES      = 8,
   parameter int WORD_WIDTH = 8,
   parameter int DEPTH      = 1024,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   weight_bank_ring_if.slave    bus,
   output logic [BANK_W-1:0]    fill_bank,
   output logic [BANK_W-1:0]    read_bank,
   output logic [BANK_W:0]      ready_cnt,
   output logic                 err_underrun,
   output logic                 err_release,
   output logic [NUM_BANKS-1:0] bank_ready
);
   localparam int ROW_W = LANES * WORD_WIDTH;
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

   typedef enum logic {BANK_FREE, BANK_READY} bank_state_t;

   bank_state_t       state_q [NUM_BANKS];
   bank_state_t       state_d [NUM_BANKS];
   logic [BANK_W-1:0] fill_d, read_d;
   logic [BANK_W:0]   ready_cnt_d;
   logic              wr_acc, commit, rd_ok, rd_acc, release_acc;

   logic [ROW_W-1:0]  mem [NUM_BANKS][DEPTH];

   always_comb begin
      wr_acc      = bus.wr_valid && (state_q[fill_bank] == BANK_FREE);
      commit      = wr_acc && bus.wr_last;
      rd_ok       = (state_q[read_bank] == BANK_READY);
      rd_acc      = bus.rd_en && rd_ok;
      release_acc = bus.rd_release && rd_ok;
   end

   assign bus.wr_ready = (state_q[fill_bank] == BANK_FREE);

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_ready[b] = (state_q[b] == BANK_READY);
      end
   end

   // Commit and release never target the same bank: one needs FREE, the other READY.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         state_d[b] = state_q[b];
      end
      fill_d      = fill_bank;
      read_d      = read_bank;
      ready_cnt_d = ready_cnt;
      if (commit) begin
         state_d[fill_bank] = BANK_READY;
         fill_d = (fill_bank == LAST_BANK) ? '0 : fill_bank + 1'b1;
      end
      if (release_acc) begin
         state_d[read_bank] = BANK_FREE;
         read_d = (read_bank == LAST_BANK) ? '0 : read_bank + 1'b1;
      end
      if (commit && !release_acc) begin
         ready_cnt_d = ready_cnt + 1'b1;
      end else if (release_acc && !commit) begin
         ready_cnt_d = ready_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= BANK_FREE;
         end
         fill_bank    <= '0;
         read_bank    <= '0;
         ready_cnt    <= '0;
         err_underrun <= 1'b0;
         err_release  <= 1'b0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= state_d[b];
         end
         fill_bank    <= fill_d;
         read_bank    <= read_d;
         ready_cnt    <= ready_cnt_d;
         err_underrun <= err_underrun | (bus.rd_en && !rd_ok);
         err_release  <= err_release | (bus.rd_release && !rd_ok);
      end
   end

   // Storage array is never reset so it can be swapped for SRAM macros.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[fill_bank][bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         bus.rd_valid <= rd_acc;
         if (rd_acc) begin
            bus.rd_data <= mem[read_bank][bus.rd_addr];
         end
      end
   end
endmodule

// File: tb/tb_weight_bank_ring.sv
// Directed bench: a 2-bank and a 3-bank ring driven side by side with hand-computed expectations.
module tb_weight_bank_ring;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   weight_bank_ring_if #(.LANES(8), .WORD_WIDTH(8), .ADDR_W(4)) i2 ();
   weight_bank_ring_if #(.LANES(8), .WORD_WIDTH(8), .ADDR_W(4)) i3 ();

   logic [0:0] fill2, read2;
   logic [1:0] cnt2, br2;
   logic       eu2, er2;
   logic [1:0] fill3, read3;
   logic [2:0] cnt3, br3;
   logic       eu3, er3;

   weight_bank_ring #(.NUM_BANKS(2), .LANES(8), .WORD_WIDTH(8), .DEPTH(16)) u2 (
      .clk(clk), .reset(reset), .bus(i2), .fill_bank(fill2), .read_bank(read2),
      .ready_cnt(cnt2), .err_underrun(eu2), .err_release(er2), .bank_ready(br2)
   );

   weight_bank_ring #(.NUM_BANKS(3), .LANES(8), .WORD_WIDTH(8), .DEPTH(16)) u3 (
      .clk(clk), .reset(reset), .bus(i3), .fill_bank(fill3), .read_bank(read3),
      .ready_cnt(cnt3), .err_underrun(eu3), .err_release(er3), .bank_ready(br3)
   );

   function automatic logic [63:0] rep(input logic [7:0] b);
      return {8{b}};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task tick;
      @(posedge clk);
      #1;
   endtask

   task automatic w2(input logic [3:0] a, input logic [7:0] b, input logic last);
      i2.wr_valid = 1'b1; i2.wr_addr = a; i2.wr_data = rep(b); i2.wr_last = last;
      tick();
      i2.wr_valid = 1'b0; i2.wr_last = 1'b0;
   endtask

   task automatic r2(input logic [3:0] a);
      i2.rd_en = 1'b1; i2.rd_addr = a;
      tick();
      i2.rd_en = 1'b0;
   endtask

   task automatic rel2;
      i2.rd_release = 1'b1;
      tick();
      i2.rd_release = 1'b0;
   endtask

   task automatic w3(input logic [3:0] a, input logic [7:0] b, input logic last);
      i3.wr_valid = 1'b1; i3.wr_addr = a; i3.wr_data = rep(b); i3.wr_last = last;
      tick();
      i3.wr_valid = 1'b0; i3.wr_last = 1'b0;
   endtask

   task automatic r3(input logic [3:0] a);
      i3.rd_en = 1'b1; i3.rd_addr = a;
      tick();
      i3.rd_en = 1'b0;
   endtask

   task automatic rel3;
      i3.rd_release = 1'b1;
      tick();
      i3.rd_release = 1'b0;
   endtask

   initial begin
      i2.wr_valid = 0; i2.wr_addr = 0; i2.wr_data = 0; i2.wr_last = 0;
      i2.rd_en = 0; i2.rd_addr = 0; i2.rd_release = 0;
      i3.wr_valid = 0; i3.wr_addr = 0; i3.wr_data = 0; i3.wr_last = 0;
      i3.rd_en = 0; i3.rd_addr = 0; i3.rd_release = 0;
      tick(); tick();

      // reset values
      chk("rst_fill2", fill2, 0);
      chk("rst_read2", read2, 0);
      chk("rst_cnt2", cnt2, 0);
      chk("rst_wr_ready2", i2.wr_ready, 1);
      chk("rst_rd_valid2", i2.rd_valid, 0);
      chk("rst_rd_data2", i2.rd_data, 0);
      chk("rst_err2", {eu2, er2}, 0);
      chk("rst_fill3", fill3, 0);
      chk("rst_wr_ready3", i3.wr_ready, 1);
      reset = 1'b1;
      tick();

      // underrun / bad release straight after reset
      r2(4'd0);
      chk("under_rd_valid", i2.rd_valid, 0);
      chk("under_err", eu2, 1);
      chk("under_rd_data", i2.rd_data, 0);
      rel2();
      chk("bad_release_err", er2, 1);
      chk("bad_release_read", read2, 0);
      tick();
      chk("under_sticky", eu2, 1);

      // fill bank 0 of the 2-bank ring and read row 2
      w2(4'd0, 8'h01, 0);
      w2(4'd1, 8'h02, 0);
      w2(4'd2, 8'h03, 0);
      w2(4'd3, 8'h04, 1);
      chk("t1_cnt", cnt2, 1);
      chk("t1_fill", fill2, 1);
      chk("t1_wr_ready", i2.wr_ready, 1);
      r2(4'd2);
      chk("t1_rd_valid", i2.rd_valid, 1);
      chk("t1_rd_data", i2.rd_data, rep(8'h03));
      tick();
      chk("t1_rd_valid_drop", i2.rd_valid, 0);
      chk("t1_rd_data_hold", i2.rd_data, rep(8'h03));

      // fill bank 1 too: ring full, extra write dropped
      w2(4'd0, 8'h11, 0);
      w2(4'd1, 8'h12, 0);
      w2(4'd2, 8'h13, 0);
      w2(4'd3, 8'h14, 1);
      chk("t2_cnt_full", cnt2, 2);
      chk("t2_wr_ready_low", i2.wr_ready, 0);
      chk("t2_fill_wrap", fill2, 0);
      w2(4'd0, 8'hFF, 1);
      chk("t2_drop_cnt", cnt2, 2);
      chk("t2_drop_fill", fill2, 0);
      r2(4'd0);
      chk("t2_drop_data", i2.rd_data, rep(8'h01));
      rel2();
      chk("t2_rel_read", read2, 1);
      chk("t2_rel_cnt", cnt2, 1);
      chk("t2_wr_ready_back", i2.wr_ready, 1);
      w2(4'd0, 8'h55, 0);
      r2(4'd1);
      chk("t2_bank1_row1", i2.rd_data, rep(8'h12));
      w2(4'd1, 8'h56, 1);
      chk("t2_recommit_cnt", cnt2, 2);
      chk("t2_recommit_fill", fill2, 1);
      rel2();
      chk("t2_read_wrap", read2, 0);
      r2(4'd0);
      chk("t2_rewrite_data", i2.rd_data, rep(8'h55));

      // 3-bank ring: commit + release + read in the same cycle
      chk("t5_fill_c0", fill3, 0);
      w3(4'd0, 8'h01, 0);
      w3(4'd1, 8'h02, 1);
      chk("t4_cnt_pre", cnt3, 1);
      w3(4'd0, 8'h11, 0);
      i3.wr_valid = 1; i3.wr_addr = 4'd1; i3.wr_data = rep(8'h12); i3.wr_last = 1;
      i3.rd_en = 1; i3.rd_addr = 4'd1; i3.rd_release = 1;
      tick();
      i3.wr_valid = 0; i3.wr_last = 0; i3.rd_en = 0; i3.rd_release = 0;
      chk("t4_cnt_same", cnt3, 1);
      chk("t4_fill_adv", fill3, 2);
      chk("t4_read_adv", read3, 1);
      chk("t4_rd_valid", i3.rd_valid, 1);
      chk("t4_old_bank_data", i3.rd_data, rep(8'h02));
      r3(4'd0);
      chk("t5_data_c1_r0", i3.rd_data, rep(8'h11));
      r3(4'd1);
      chk("t5_data_c1_r1", i3.rd_data, rep(8'h12));
      rel3();
      chk("t5_read_c1", read3, 2);
      chk("t5_cnt_c1", cnt3, 0);

      for (int c = 2; c < 5; c++) begin
         chk($sformatf("t5_fill_c%0d", c), fill3, 64'(c % 3));
         w3(4'd0, 8'(c * 16 + 1), 0);
         w3(4'd1, 8'(c * 16 + 2), 1);
         chk($sformatf("t5_cnt_c%0d", c), cnt3, 1);
         r3(4'd1);
         chk($sformatf("t5_data_c%0d_r1", c), i3.rd_data, rep(8'(c * 16 + 2)));
         r3(4'd0);
         chk($sformatf("t5_data_c%0d_r0", c), i3.rd_data, rep(8'(c * 16 + 1)));
         rel3();
         chk($sformatf("t5_read_c%0d", c), read3, 64'((c + 1) % 3));
      end

      // async reset mid-fill, with a read just returned
      chk("t6_pre_fill2", fill2, 1);
      w2(4'd0, 8'h77, 0);
      r2(4'd1);
      chk("t6_pre_rd_valid", i2.rd_valid, 1);
      w3(4'd0, 8'h61, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_fill2", fill2, 0);
      chk("t6_read2", read2, 0);
      chk("t6_cnt2", cnt2, 0);
      chk("t6_rd_valid2", i2.rd_valid, 0);
      chk("t6_rd_data2", i2.rd_data, 0);
      chk("t6_err2", {eu2, er2}, 0);
      chk("t6_wr_ready2", i2.wr_ready, 1);
      chk("t6_fill3", fill3, 0);
      chk("t6_read3", read3, 0);
      chk("t6_cnt3", cnt3, 0);
      chk("t6_wr_ready3", i3.wr_ready, 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
